// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator: default geometry,
// FSM state encoding and the window element index helper.
package win_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int DW_DEF    = 9;

  // Number of elements in a 3x3 window.
  localparam int WIN_N = 9;

  // S_FILL while rows 0 and 1 are still arriving, S_RUN once a full
  // three-row band exists.
  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Flat element index of window position (i, j): i = row (0 oldest),
  // j = column (0 oldest).
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
// With WIN_COORD_EN defined the bundle also carries the window centre
// coordinate (win_row_o, win_col_o) and takes IMG_W/IMG_H to size it.
interface window_3x3_gen_if
  import win_pkg::*;
#(
  parameter int DW = DW_DEF
`ifdef WIN_COORD_EN
  ,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
`endif
) ();

  logic                   de_i;
  logic signed [DW-1:0]   data_i;
  logic                   de_o;
  logic [WIN_N*DW-1:0]    win_o;
  logic                   frame_done_o;
`ifdef WIN_COORD_EN
  logic [$clog2(IMG_H)-1:0] win_row_o;
  logic [$clog2(IMG_W)-1:0] win_col_o;
`endif

  // Pixel source / window sink side.
  modport master (
    output de_i, data_i,
    input  de_o, win_o, frame_done_o
`ifdef WIN_COORD_EN
    ,
    input  win_row_o, win_col_o
`endif
  );

  // Window generator side.
  modport slave (
    input  de_i, data_i,
    output de_o, win_o, frame_done_o
`ifdef WIN_COORD_EN
    ,
    output win_row_o, win_col_o
`endif
  );

endinterface

// File: rtl/window_3x3_gen_line_buf.sv
// Line buffer: delays the pixel stream by exactly DEPTH accepted pixels.
// Advances only when en is high, so input gaps do not disturb alignment.
module line_buf #(
  parameter int DEPTH = 128,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];

  // Shift one position per accepted pixel.
  // NOTE: the storage has no reset; its contents are never observed until
  // DEPTH fresh pixels have pushed any stale data out, and a reset on a
  // memory prevents RAM/SRL mapping.
  // NOTE: sequential state is assigned with <= so every stage reads the
  // pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator for a raster pixel stream (valid
// convolution, no padding). Two line buffers supply the two previous rows;
// a 3x2 column history plus the incoming column forms the window, which is
// registered and presented one cycle after the accepted pixel.
// Optional feature: define WIN_COORD_EN to add win_row_o/win_col_o, the
// window centre coordinate registered alongside de_o.
module window_3x3_gen
  import win_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  window_3x3_gen_if.slave  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  state_t        state_q;

  logic                accept;
  logic                col_last;
  logic                row_last;
  logic                emit;
  logic [DW-1:0]       lb1_dout;
  logic [DW-1:0]       lb2_dout;
  logic [DW-1:0]       new_col [3];
  logic [DW-1:0]       hist_q  [3][2];
  logic [WIN_N*DW-1:0] win_d;
  logic [WIN_N*DW-1:0] win_q;
  logic                de_q;
  logic                fd_q;

  assign accept   = bus.de_i;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  // Columns 0 and 1 would straddle the previous line, so they never emit.
  assign emit     = accept && (state_q == S_RUN) && (col_q >= CW'(2));

  // Raster position of the pixel presented on data_i.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position counters; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (bus.data_i),
    .dout (lb1_dout)
  );

  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Incoming column, oldest row first.
  always_comb begin
    new_col[0] = lb2_dout;
    new_col[1] = lb1_dout;
    new_col[2] = bus.data_i;
  end

  // Column history: the two columns preceding the incoming one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        hist_q[i][0] <= '0;
        hist_q[i][1] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        hist_q[i][0] <= hist_q[i][1];
        hist_q[i][1] <= new_col[i];
      end
    end
  end

  // Assemble the window the accepted pixel completes.
  always_comb begin
    win_d = '0;
    for (int i = 0; i < 3; i++) begin
      win_d[win_idx(i, 0)*DW +: DW] = hist_q[i][0];
      win_d[win_idx(i, 1)*DW +: DW] = hist_q[i][1];
      win_d[win_idx(i, 2)*DW +: DW] = new_col[i];
    end
  end

  // Fill/run FSM with registered window outputs; win_q holds between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      de_q    <= 1'b0;
      fd_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      de_q <= emit;
      fd_q <= emit && col_last && row_last;
      if (emit) begin
        win_q <= win_d;
      end
      if (accept && col_last) begin
        case (state_q)
          S_FILL: if (row_q == RW'(1)) state_q <= S_RUN;
          S_RUN:  if (row_last)        state_q <= S_FILL;
        endcase
      end
    end
  end

  assign bus.de_o         = de_q;
  assign bus.win_o        = win_q;
  assign bus.frame_done_o = fd_q;

`ifdef WIN_COORD_EN
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  // Window centre is one row and one column behind the accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (emit) begin
      win_row_q <= row_q - RW'(1);
      win_col_q <= col_q - CW'(1);
    end
  end

  assign bus.win_row_o = win_row_q;
  assign bus.win_col_o = win_col_q;
`else
  // Coordinate outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on an 8x8 image. The model keeps
// the current frame as a 2-D array indexed by the raster position the
// bench itself drives, and derives each expected window directly from it.
module tb_window_3x3_gen;
  import win_pkg::*;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int DW   = 9;
  localparam int NWIN = (H - 2) * (W - 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  window_3x3_gen_if #(
    .DW(DW)
`ifdef WIN_COORD_EN
    , .IMG_W(W), .IMG_H(H)
`endif
  ) bus_if ();

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Model state
  logic [DW-1:0]       img [H][W];
  bit                  exp_de;
  bit                  exp_fd;
  logic [WIN_N*DW-1:0] exp_win;
  logic [WIN_N*DW-1:0] last_win;
  int                  exp_r, exp_c, last_r, last_c;
  bit                  m_first_pending;
  logic [WIN_N*DW-1:0] m_first;
  logic [WIN_N*DW-1:0] m_fd_win;
  int                  m_first_r, m_first_c, m_fd_r, m_fd_c;

  int win_cnt = 0;
  int fd_cnt  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare, on the falling edge, against what the model
  // predicted for the pixel driven in the previous cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("de_o", bus_if.de_o, exp_de);
        if (bus_if.de_o) win_cnt++;
        if (bus_if.frame_done_o) fd_cnt++;
        if (exp_de) begin
          check("win_o", bus_if.win_o, exp_win);
          check("frame_done_o", bus_if.frame_done_o, exp_fd);
`ifdef WIN_COORD_EN
          check("win_row_o", bus_if.win_row_o, exp_r);
          check("win_col_o", bus_if.win_col_o, exp_c);
`endif
          last_win = exp_win;
          last_r   = exp_r;
          last_c   = exp_c;
        end else begin
          check("win_o_hold", bus_if.win_o, last_win);
          check("frame_done_idle", bus_if.frame_done_o, 1'b0);
`ifdef WIN_COORD_EN
          check("win_row_hold", bus_if.win_row_o, last_r);
          check("win_col_hold", bus_if.win_col_o, last_c);
`endif
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    #1;
    bus_if.de_i   = 1'b0;
    bus_if.data_i = DW'($urandom);
    exp_de = 1'b0;
    exp_fd = 1'b0;
  endtask

  task automatic send_pixel(input int r, input int c, input logic [DW-1:0] v);
    @(negedge clk);
    #1;
    bus_if.de_i   = 1'b1;
    bus_if.data_i = v;
    img[r][c]     = v;
    exp_de = (r >= 2) && (c >= 2);
    exp_fd = (r == H - 1) && (c == W - 1);
    if (exp_de) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
      exp_r = r - 1;
      exp_c = c - 1;
      if (m_first_pending) begin
        m_first         = exp_win;
        m_first_r       = exp_r;
        m_first_c       = exp_c;
        m_first_pending = 1'b0;
      end
      if (exp_fd) begin
        m_fd_win = exp_win;
        m_fd_r   = exp_r;
        m_fd_c   = exp_c;
      end
    end
  endtask

  // mode 0: ramp r*8+c, 1: all -255, 2: random. max_gap 0 = continuous.
  task automatic send_frame(input int mode, input int max_gap, input int rows);
    logic [DW-1:0] v;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (max_gap > 0 && $urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, max_gap)) idle();
        case (mode)
          0:       v = DW'(r * 8 + c);
          1:       v = DW'(-255);
          default: v = DW'($urandom);
        endcase
        send_pixel(r, c, v);
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_n         = 1'b0;
    bus_if.de_i   = 1'b0;
    exp_de        = 1'b0;
    exp_fd        = 1'b0;
    last_win      = '0;
    last_r        = 0;
    last_c        = 0;
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    win_cnt         = 0;
    fd_cnt          = 0;
    m_first_pending = 1'b1;
  endtask

  logic [DW-1:0] e;

  initial begin
    bus_if.de_i   = 1'b0;
    bus_if.data_i = '0;
    exp_de   = 1'b0;
    exp_fd   = 1'b0;
    exp_win  = '0;
    last_win = '0;
    exp_r = 0; exp_c = 0; last_r = 0; last_c = 0;
    m_first = '0; m_fd_win = '0;
    m_first_r = 0; m_first_c = 0; m_fd_r = 0; m_fd_c = 0;
    m_first_pending = 1'b1;

    #1;
    rst_n    = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_de_o", bus_if.de_o, 1'b0);
    check("reset_win_o", bus_if.win_o, '0);
    check("reset_frame_done_o", bus_if.frame_done_o, 1'b0);

    // Ramp frame, continuous input
    clear_counts();
    send_frame(0, 0, H);
    repeat (3) idle();
    check("ramp_windows", win_cnt, NWIN);
    check("ramp_frame_done", fd_cnt, 1);
    e = m_first[0 +: DW];          check("ramp_first_e00", e, 9'd0);
    e = m_first[8*DW +: DW];       check("ramp_first_e22", e, 9'd18);
    e = m_fd_win[8*DW +: DW];      check("ramp_last_e22", e, 9'd63);
`ifdef WIN_COORD_EN
    check("coord_first_row", m_first_r, 1);
    check("coord_first_col", m_first_c, 1);
    check("coord_last_row", m_fd_r, 6);
    check("coord_last_col", m_fd_c, 6);
`endif

    // Ramp frame with random input gaps
    clear_counts();
    send_frame(0, 5, H);
    repeat (3) idle();
    check("gap_windows", win_cnt, NWIN);
    check("gap_frame_done", fd_cnt, 1);

    // Two back-to-back ramp frames
    clear_counts();
    send_frame(0, 0, H);
    m_first_pending = 1'b1;
    send_frame(0, 0, H);
    repeat (3) idle();
    check("b2b_windows", win_cnt, 2 * NWIN);
    check("b2b_frame_done", fd_cnt, 2);
    e = m_first[0 +: DW];          check("b2b_second_first_e00", e, 9'd0);

    // Constant -255 frame
    clear_counts();
    send_frame(1, 2, H);
    repeat (3) idle();
    check("neg_windows", win_cnt, NWIN);
    e = m_first[0 +: DW];          check("neg_e00", e, 9'h101);
    e = m_first[4*DW +: DW];       check("neg_e11", e, 9'h101);

    // Partial frame, reset after row 3, then a full frame
    clear_counts();
    send_frame(0, 2, 4);
    repeat (2) idle();
    check("partial_windows", win_cnt, 2 * (W - 2));
    do_reset(3);
    clear_counts();
    send_frame(0, 3, H);
    repeat (3) idle();
    check("post_reset_windows", win_cnt, NWIN);
    check("post_reset_frame_done", fd_cnt, 1);

    // Three back-to-back random frames with random gaps
    clear_counts();
    for (int f = 0; f < 3; f++) send_frame(2, 3, H);
    repeat (3) idle();
    check("rand_windows", win_cnt, 3 * NWIN);
    check("rand_frame_done", fd_cnt, 3);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter IMG_W, default 128, meaning pixels per line of the incoming upsampled stream (minimum 4).
REQ-002 Parameter IMG_H, default 128, meaning lines per frame (minimum 3).
REQ-003 Parameter DW, default 9, meaning signed pixel width.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 de_i  input  1  pixel valid; the pixel is accepted on every cycle it is high, raster order, gaps allowed.
REQ-007 data_i  input  DW  signed pixel, the 128x128 output of the upsample/deconv stage.
REQ-008 de_o  output  1  window valid.
REQ-009 win_o  output  9*DW  3x3 window; element (i,j) at bits [(3*i+j)*DW +: DW]; i=0 is the oldest row, j=0 the oldest column.
REQ-010 frame_done_o  output  1  one-cycle pulse marking the last window of a frame.

Function
REQ-011 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance only on de_i; col wraps to 0 after IMG_W-1 and increments row; row wraps to 0 after IMG_H-1.
REQ-012 FSM states: S_FILL (row<2) and S_RUN (row>=2); S_FILL->S_RUN on the accepted pixel with col=IMG_W-1, row=1; S_RUN->S_FILL on the accepted pixel with col=IMG_W-1, row=IMG_H-1.
REQ-013 Two line buffers SHALL delay accepted pixels by exactly IMG_W accepted pixels (lb1 out) and 2*IMG_W accepted pixels (lb2 out), advancing only on de_i.
REQ-014 A 3x3 column shift register SHALL shift {lb2 out, lb1 out, data_i} in on each accepted pixel.
REQ-015 Window for input pixel (r,c) SHALL be rows r-2..r, cols c-2..c (valid convolution, no padding); element (2,2) equals data_i.
REQ-016 de_o SHALL be high exactly one cycle after an accepted pixel with state S_RUN and col>=2; latency 1 cycle; (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-017 win_o SHALL hold its last value while de_o is low.
REQ-018 frame_done_o SHALL pulse coincident with de_o for pixel (IMG_H-1, IMG_W-1).
REQ-019 Window columns SHALL never mix data across a line boundary: windows at col 0 and 1 are suppressed, not emitted.
REQ-020 Back-to-back frames (no de_i gap at the frame boundary) SHALL work with no lost or extra windows.
REQ-021 Pixel values SHALL pass through bit-exact; no arithmetic.

Reset
REQ-022 On rst_n low: de_o=0, win_o=0, frame_done_o=0, col=0, row=0, state S_FILL; line-buffer contents need not be cleared.
REQ-023 Reset mid-frame SHALL abandon the partial frame; the first pixel after release is treated as (0,0).

Configuration
REQ-024 Macro WIN_COORD_EN defined: extra outputs win_row_o and win_col_o (each $clog2(IMG_H)/$clog2(IMG_W) bits, reset 0) give the centre coordinate (r-1, c-1) of the window, registered with de_o.
REQ-025 Macro WIN_COORD_EN undefined: those ports and their logic are absent; all other behaviour unchanged.

Structure
REQ-026 Package win_pkg SHALL hold the defaults of IMG_W, IMG_H, DW, the FSM state enum and the window index helper constant WIN_N=9.
REQ-027 Sub-module line_buf (parameters DEPTH, DW; ports clk, en, din, dout) SHALL implement each delay line; instantiated twice.

Verification
REQ-028 IMG_W=IMG_H=8, continuous de_i, data=r*8+c -> first de_o one cycle after pixel (2,2), win_o elements (0,0)=0, (2,2)=18; 36 windows; frame_done_o with window (2,2)=63.
REQ-029 Same frame with random de_i gaps (1-5 cycles) -> identical 36 windows in identical order.
REQ-030 Two back-to-back frames -> 72 windows, frame_done_o exactly twice, second frame's first window (0,0)=0.
REQ-031 All pixels -255 -> every element 9'h101, no sign corruption.
REQ-032 rst_n pulsed after row 3 of a frame, then full frame -> de_o low during reset, 36 correct windows afterwards.
REQ-033 WIN_COORD_EN defined, 8x8 ramp -> first window reports (1,1), last reports (6,6).
